conv_enc_frame_ctrl: RTL and testbench
======================================

Name: conv_enc_frame_ctrl

Overview:
- Frame sequencer for the convolutional encoder.
- Accepts a bit stream with valid/ready/last and drives the encoder's data_in, in_enable and constraint_sel.
- After each frame's last bit it appends K-1 zero tail bits, so the encoder ends every frame in the all-zero state. The encoder shares this block's rst, so it also starts from zero.
- Generates an aligned symbol-valid/last strobe for the registered encoded_out0/encoded_out1 pair, so downstream logic does not use the encoder's out_enable.

Parameters:
- MAX_FRAME_LEN, 1024: maximum data bits per frame; an overlong frame is force-terminated.
- CNT_W, 11: width of bit_count; must satisfy 2^CNT_W > MAX_FRAME_LEN.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_constraint_sel  in  2  requested K: 00=K3, 01=K4, 10=K5, 11=K7
- s_data  in  1  input data bit
- s_valid  in  1  input bit valid
- s_last  in  1  marks the final data bit of the frame
- s_ready  out  1  controller accepts a bit this cycle
- enc_data_in  out  1  to encoder data_in (registered)
- enc_in_enable  out  1  to encoder in_enable (registered)
- enc_constraint_sel  out  2  to encoder constraint_sel (registered, frozen per frame)
- sym_valid  out  1  encoder output pair valid this cycle
- sym_last  out  1  final symbol of the frame (last tail symbol)
- busy  out  1  high in any state other than IDLE
- bit_count  out  CNT_W  data bits accepted in the current frame
- err_overlen  out  1  one-cycle pulse when a frame is force-terminated

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, delay pipeline cleared. Exception: s_ready is 1 in the first cycle after reset, because IDLE drives it high.
- Accept condition: acc = s_valid & s_ready.
- States: IDLE, DATA, TAIL, DRAIN.
- IDLE:
  - s_ready=1 and busy=0.
  - enc_constraint_sel <= cfg_constraint_sel every cycle, including the acceptance edge.
  - On acc: bit_count <= 1 and the bit is issued. Next state is DATA, or TAIL if the bit is last (s_last or overlength).
- DATA:
  - s_ready=1.
  - Each acc issues the bit and increments bit_count.
  - On an accepted last bit go to TAIL; s_ready=0 from the next cycle.
- Issue rule: a bit accepted on edge E appears as enc_in_enable=1, enc_data_in=bit in the cycle after E. When no bit is accepted, enc_in_enable=0.
- Frozen config: enc_constraint_sel stays constant from the first acceptance until IDLE is re-entered. Changes on cfg_constraint_sel during a frame are ignored.
- TAIL:
  - s_ready=0.
  - Issues tail_len = K-1 zero bits (2/3/4/6 for sel 00/01/10/11) on consecutive cycles, counted by a tail counter.
  - The strobe for the final tail bit is tagged last.
  - Then go to DRAIN.
- DRAIN:
  - s_ready=0, no strobes.
  - Wait until sym_last has asserted, then go to IDLE on the following edge.
- Symbol alignment:
  - sym_valid = enc_in_enable delayed 2 cycles.
  - sym_last = the "last" tag delayed 2 cycles.
  - The 2-cycle delay covers the encoder's shift-register update plus its registered output.
  - Latency from bit acceptance to sym_valid is 3 cycles.
- Symbol count: exactly N + K-1 sym_valid pulses per frame of N data bits; sym_last fires exactly once, on the final one.
- Overlength: if the bit accepted brings bit_count to MAX_FRAME_LEN and s_last=0, it is treated as last and err_overlen pulses for one cycle after the accepting edge. Subsequent input bits wait for the next frame.
- Single-bit frame: a bit accepted in IDLE with s_last=1 goes directly to TAIL.
- Back-to-back frames:
  - A new frame cannot be accepted until IDLE.
  - Minimum gap from the last data-bit acceptance to the next frame's first acceptance is tail_len + 3 cycles.
  - No input bit is dropped; s_valid may stay high and it waits.
- bit_count holds its final value through TAIL/DRAIN and resets to 1 on the next frame's first acceptance.
- s_valid low mid-frame: no strobe is issued and the state is held; encoder state is preserved.
- Reset mid-frame: next cycle is IDLE with the pipeline flushed, so no sym_valid/sym_last after reset. The encoder is reset by the same rst.

Test Plan:
- K3 (sel=00), frame 1,0,1,1 with continuous s_valid:
  - 6 sym_valid pulses on consecutive cycles, the first 3 cycles after the first acceptance.
  - (out0,out1) = 11,10,00,01,01,11.
  - sym_last on the 6th; bit_count=4.
- Tail length per K, 3-bit frame at each sel: 00→5, 01→6, 10→7, 11→9 symbols. Encoder outputs are 00 for the cycle after each frame.
- Change cfg_constraint_sel 00→11 mid-frame:
  - enc_constraint_sel stays 00 until IDLE; tail is 2 bits.
  - The next frame uses 11.
- Gapped s_valid (1 on, 2 off) over an 8-bit frame: exactly 8 data strobes plus the tail, with no strobes in gap cycles.
- MAX_FRAME_LEN=8, 12 bits with s_last=0:
  - err_overlen pulses after the 8th acceptance; 8+K-1 symbols.
  - The remaining 4 bits start a new frame after DRAIN.
- Assert rst during TAIL: the next cycle shows IDLE, s_ready=1, busy=0, and sym_valid stays 0 until a new frame.

Source files
------------

// File: rtl/conv_enc_frame_ctrl.sv
// Frames a serial bit stream for the convolutional encoder: issues data bits, appends K-1 zero tail bits, tags symbols.
// Latency: accepted bit -> enc_in_enable 1 cycle; accepted bit -> sym_valid 3 cycles (encoder update + encoder output register).
// Backpressure: s_ready high only in IDLE/DATA; a waiting s_valid is held (never dropped) through TAIL/DRAIN until IDLE.
module conv_enc_frame_ctrl #(
    parameter int MAX_FRAME_LEN = 1024,
    parameter int CNT_W         = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cfg_constraint_sel,
    input  logic             s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic             enc_data_in,
    output logic             enc_in_enable,
    output logic [1:0]       enc_constraint_sel,
    output logic             sym_valid,
    output logic             sym_last,
    output logic             busy,
    output logic [CNT_W-1:0] bit_count,
    output logic             err_overlen
);

    typedef enum logic [1:0] {IDLE, DATA, TAIL, DRAIN} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_FRAME_LEN);

    state_t           state;
    state_t           state_nxt;
    logic             acc;
    logic             overlen;
    logic             is_last;
    logic [CNT_W-1:0] cnt_nxt;
    logic             issue_vld;
    logic             issue_dat;
    logic             issue_last;
    logic [2:0]       tail_len;
    logic [2:0]       tail_cnt;
    logic             tail_done;
    logic             last_tag;     // travels alongside enc_in_enable
    logic [1:0]       vld_pipe;
    logic [1:0]       last_pipe;

    // Tail length is K-1, taken from the configuration frozen for this frame.
    always_comb begin
        tail_len = 3'd2;
        case (enc_constraint_sel)
            2'b00:   tail_len = 3'd2;
            2'b01:   tail_len = 3'd3;
            2'b10:   tail_len = 3'd4;
            default: tail_len = 3'd6;
        endcase
    end

    assign tail_done = (tail_cnt == (tail_len - 3'd1));

    // Next-state, handshake and issue decisions.
    always_comb begin
        state_nxt  = state;
        s_ready    = 1'b0;
        acc        = 1'b0;
        cnt_nxt    = bit_count;
        overlen    = 1'b0;
        is_last    = 1'b0;
        issue_vld  = 1'b0;
        issue_dat  = 1'b0;
        issue_last = 1'b0;
        case (state)
            IDLE: begin
                s_ready = 1'b1;
                acc     = s_valid;
                cnt_nxt = CNT_W'(1);
            end
            DATA: begin
                s_ready = 1'b1;
                acc     = s_valid;
                cnt_nxt = bit_count + CNT_W'(1);
            end
            TAIL: begin
                issue_vld  = 1'b1;
                issue_last = tail_done;
                if (tail_done) begin
                    state_nxt = DRAIN;
                end
            end
            default: begin
                // DRAIN: leave once the final tagged symbol has left the pipe.
                if (sym_last) begin
                    state_nxt = IDLE;
                end
            end
        endcase
        if (acc) begin
            issue_vld = 1'b1;
            issue_dat = s_data;
            overlen   = !s_last && (cnt_nxt == MAX_CNT);
            is_last   = s_last || overlen;
            state_nxt = is_last ? TAIL : DATA;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Encoder drive, frame counters and the symbol-alignment delay line.
    always_ff @(posedge clk) begin
        if (rst) begin
            enc_in_enable      <= 1'b0;
            enc_data_in        <= 1'b0;
            enc_constraint_sel <= 2'b00;
            last_tag           <= 1'b0;
            vld_pipe           <= 2'b00;
            last_pipe          <= 2'b00;
            err_overlen        <= 1'b0;
            bit_count          <= '0;
            tail_cnt           <= 3'd0;
        end else begin
            enc_in_enable <= issue_vld;
            enc_data_in   <= issue_dat;
            last_tag      <= issue_last;
            vld_pipe      <= {vld_pipe[0], enc_in_enable};
            last_pipe     <= {last_pipe[0], last_tag};
            err_overlen   <= overlen;
            if (state == IDLE) begin
                enc_constraint_sel <= cfg_constraint_sel;
            end
            if (acc) begin
                bit_count <= cnt_nxt;
            end
            if (state == TAIL) begin
                tail_cnt <= tail_cnt + 3'd1;
            end else begin
                tail_cnt <= 3'd0;
            end
        end
    end

    assign sym_valid = vld_pipe[1];
    assign sym_last  = last_pipe[1];
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_conv_enc_frame_ctrl.sv
// Scoreboard bench for conv_enc_frame_ctrl with a K=3 (7,5) encoder model for output alignment.
// Expected issued bits and symbol last-tags are queued at stimulus time and popped by a negedge monitor.
// Every wait on the DUT is bounded; the run always ends with one summary line.
module tb_conv_enc_frame_ctrl;

    localparam int MAXL = 8;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    cfg = 2'b00;
    logic          s_data = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          enc_data_in;
    logic          enc_in_enable;
    logic [1:0]    enc_constraint_sel;
    logic          sym_valid;
    logic          sym_last;
    logic          busy;
    logic [CW-1:0] bit_count;
    logic          err_overlen;

    conv_enc_frame_ctrl #(.MAX_FRAME_LEN(MAXL), .CNT_W(CW)) dut (
        .clk                (clk),
        .rst                (rst),
        .cfg_constraint_sel (cfg),
        .s_data             (s_data),
        .s_valid            (s_valid),
        .s_last             (s_last),
        .s_ready            (s_ready),
        .enc_data_in        (enc_data_in),
        .enc_in_enable      (enc_in_enable),
        .enc_constraint_sel (enc_constraint_sel),
        .sym_valid          (sym_valid),
        .sym_last           (sym_last),
        .busy               (busy),
        .bit_count          (bit_count),
        .err_overlen        (err_overlen)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic       exp_bits[$];
    logic       exp_last[$];
    logic [1:0] cap_out[$];
    int sym_cnt = 0, iss_cnt = 0, err_cnt = 0;
    int first_sym = 0, last_sym = 0, err_cyc = 0;
    logic mon_e;

    // K=3 encoder model: window update on in_enable, registered outputs one edge later.
    logic [2:0] w;
    logic       eo0, eo1;
    always @(posedge clk) begin
        if (rst) begin
            w <= 3'b000; eo0 <= 1'b0; eo1 <= 1'b0;
        end else begin
            if (enc_in_enable) w <= {enc_data_in, w[2:1]};
            eo0 <= w[2] ^ w[1] ^ w[0];
            eo1 <= w[2] ^ w[0];
        end
    end

    // Monitor: pops the scoreboard on every issued bit and every symbol strobe.
    always @(negedge clk) begin
        if (!rst) begin
            if (enc_in_enable) begin
                iss_cnt++;
                checks++;
                if (exp_bits.size() == 0) begin
                    errors++;
                    $display("FAIL issue_unexpected: data=%0b issued, required no issue", enc_data_in);
                end else begin
                    mon_e = exp_bits.pop_front();
                    if (enc_data_in !== mon_e) begin
                        errors++;
                        $display("FAIL issue_data: got %0b, required %0b", enc_data_in, mon_e);
                    end
                end
            end
            if (sym_valid) begin
                if (sym_cnt == 0) first_sym = cyc;
                last_sym = cyc;
                sym_cnt++;
                cap_out.push_back({eo0, eo1});
                checks++;
                if (exp_last.size() == 0) begin
                    errors++;
                    $display("FAIL sym_unexpected: sym_last=%0b, required no symbol", sym_last);
                end else begin
                    mon_e = exp_last.pop_front();
                    if (sym_last !== mon_e) begin
                        errors++;
                        $display("FAIL sym_last_tag: got %0b, required %0b", sym_last, mon_e);
                    end
                end
            end else begin
                checks++;
                if (sym_last !== 1'b0) begin
                    errors++;
                    $display("FAIL sym_last_without_valid: got %0b, required 0", sym_last);
                end
            end
            if (err_overlen) begin
                err_cnt++;
                err_cyc = cyc;
            end
        end
    end

    function automatic int tlen(input logic [1:0] s);
        case (s)
            2'b00:   return 2;
            2'b01:   return 3;
            2'b10:   return 4;
            default: return 6;
        endcase
    endfunction

    task automatic clear_stats();
        sym_cnt = 0; iss_cnt = 0; err_cnt = 0;
        cap_out.delete();
    endtask

    task automatic push_frame(input logic [15:0] bits, input int n, input int l);
        for (int i = 0; i < n; i++) begin
            exp_bits.push_back(bits[i]);
            exp_last.push_back(1'b0);
        end
        for (int i = 0; i < l; i++) begin
            exp_bits.push_back(1'b0);
            exp_last.push_back(i == l - 1);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic drive_bit(input logic d, input logic l, output int ac);
        int t;
        logic rdy;
        t = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        rdy = s_ready; ac = cyc;
        while (!rdy && t < 300) begin
            @(negedge clk);
            t++;
            rdy = s_ready; ac = cyc;
        end
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL accept_timeout: s_ready=%0b after %0d cycles, required 1", rdy, t);
        end
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0; s_data = 1'b0;
    endtask

    task automatic drive_frame(input logic [15:0] bits, input int n, input int gap,
                               output int fa, output int la);
        int a;
        fa = 0; la = 0;
        for (int i = 0; i < n; i++) begin
            drive_bit(bits[i], i == n - 1, a);
            if (i == 0) fa = a;
            la = a;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy=%0b, required 0", nm, busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_drained(input string nm);
        checks++;
        if (exp_bits.size() != 0 || exp_last.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: %0d bits / %0d symbols outstanding, required 0/0",
                     nm, exp_bits.size(), exp_last.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({s_ready, busy, enc_in_enable, enc_data_in, sym_valid, sym_last, err_overlen} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_flags: ready,busy,en,dat,sv,sl,err=%b, required 1000000",
                     {s_ready, busy, enc_in_enable, enc_data_in, sym_valid, sym_last, err_overlen});
        end
        checks++;
        if (bit_count !== '0 || enc_constraint_sel !== 2'b00) begin
            errors++;
            $display("FAIL reset_counts: bit_count=%0d sel=%0d, required 0 0", bit_count, enc_constraint_sel);
        end
    endtask

    task automatic test_k3_frame();
        logic [1:0] tbl [6];
        int fa, la;
        tbl = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        cfg = 2'b00;
        @(negedge clk);
        clear_stats();
        push_frame(16'h000D, 4, 2);
        drive_frame(16'h000D, 4, 0, fa, la);
        wait_idle("k3");
        checks++;
        if (sym_cnt != 6) begin errors++; $display("FAIL k3_sym_count: got %0d, required 6", sym_cnt); end
        checks++;
        if (first_sym - fa != 3) begin errors++; $display("FAIL k3_latency: got %0d, required 3", first_sym - fa); end
        checks++;
        if (last_sym - first_sym != 5) begin errors++; $display("FAIL k3_consecutive: span %0d, required 5", last_sym - first_sym); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= cap_out.size() || cap_out[i] !== tbl[i]) begin
                errors++;
                $display("FAIL k3_out_pair%0d: got %b, required %b", i,
                         (i < cap_out.size()) ? cap_out[i] : 2'bxx, tbl[i]);
            end
        end
        checks++;
        if (bit_count !== 4'd4) begin errors++; $display("FAIL k3_bit_count: got %0d, required 4", bit_count); end
        check_drained("k3");
    endtask

    task automatic test_tail_len();
        int fa, la, l;
        for (int s = 0; s < 4; s++) begin
            cfg = 2'(s);
            l = tlen(2'(s));
            @(negedge clk);
            clear_stats();
            push_frame(16'h0003, 3, l);
            drive_frame(16'h0003, 3, 0, fa, la);
            checks++;
            if (enc_constraint_sel !== 2'(s)) begin
                errors++;
                $display("FAIL tail_sel%0d: enc_constraint_sel=%0d, required %0d", s, enc_constraint_sel, s);
            end
            wait_idle("tail");
            checks++;
            if (sym_cnt != 3 + l || iss_cnt != 3 + l) begin
                errors++;
                $display("FAIL tail_count_sel%0d: sym=%0d issued=%0d, required %0d", s, sym_cnt, iss_cnt, 3 + l);
            end
        end
        check_drained("tail");
    endtask

    task automatic test_cfg_freeze();
        int a, fa, la;
        cfg = 2'b00;
        @(negedge clk);
        clear_stats();
        push_frame(16'h0005, 4, 2);
        drive_bit(1'b1, 1'b0, a);
        cfg = 2'b11;
        drive_bit(1'b0, 1'b0, a);
        drive_bit(1'b1, 1'b0, a);
        drive_bit(1'b0, 1'b1, a);
        @(negedge clk);
        checks++;
        if (enc_constraint_sel !== 2'b00) begin
            errors++;
            $display("FAIL freeze_sel: got %0d, required 0", enc_constraint_sel);
        end
        wait_idle("freeze");
        checks++;
        if (sym_cnt != 6) begin errors++; $display("FAIL freeze_sym_count: got %0d, required 6", sym_cnt); end
        clear_stats();
        push_frame(16'h0002, 2, 6);
        drive_frame(16'h0002, 2, 0, fa, la);
        checks++;
        if (enc_constraint_sel !== 2'b11) begin
            errors++;
            $display("FAIL freeze_next_sel: got %0d, required 3", enc_constraint_sel);
        end
        wait_idle("freeze2");
        checks++;
        if (sym_cnt != 8) begin errors++; $display("FAIL freeze_next_count: got %0d, required 8", sym_cnt); end
        check_drained("freeze");
    endtask

    task automatic test_gapped();
        int fa, la;
        cfg = 2'b00;
        @(negedge clk);
        clear_stats();
        push_frame(16'h00B2, 8, 2);
        drive_frame(16'h00B2, 8, 2, fa, la);
        wait_idle("gap");
        checks++;
        if (iss_cnt != 10 || sym_cnt != 10) begin
            errors++;
            $display("FAIL gap_counts: issued=%0d sym=%0d, required 10 10", iss_cnt, sym_cnt);
        end
        checks++;
        if (bit_count !== 4'd8 || err_cnt != 0) begin
            errors++;
            $display("FAIL gap_final: bit_count=%0d err_pulses=%0d, required 8 0", bit_count, err_cnt);
        end
        check_drained("gap");
    endtask

    task automatic test_overlen();
        logic [15:0] bits;
        logic [15:0] b2;
        int a, a8;
        bits = 16'h1A5B;
        cfg = 2'b01;
        @(negedge clk);
        clear_stats();
        push_frame(bits, 8, 3);
        b2 = bits >> 8;
        push_frame(b2, 5, 3);
        a8 = 0;
        for (int i = 0; i < 12; i++) begin
            drive_bit(bits[i], 1'b0, a);
            if (i == 7) a8 = a;
        end
        checks++;
        if (err_cnt != 1 || err_cyc != a8 + 1) begin
            errors++;
            $display("FAIL overlen_pulse: pulses=%0d at +%0d, required 1 at +1", err_cnt, err_cyc - a8);
        end
        checks++;
        if (bit_count !== 4'd4 || busy !== 1'b1) begin
            errors++;
            $display("FAIL overlen_second_frame: bit_count=%0d busy=%0b, required 4 1", bit_count, busy);
        end
        drive_bit(bits[12], 1'b1, a);
        wait_idle("overlen");
        checks++;
        if (sym_cnt != 19 || err_cnt != 1) begin
            errors++;
            $display("FAIL overlen_totals: sym=%0d pulses=%0d, required 19 1", sym_cnt, err_cnt);
        end
        checks++;
        if (bit_count !== 4'd5) begin errors++; $display("FAIL overlen_bit_count: got %0d, required 5", bit_count); end
        check_drained("overlen");
    endtask

    task automatic test_back_to_back();
        int fa1, la1, fa2, la2;
        cfg = 2'b10;
        @(negedge clk);
        clear_stats();
        push_frame(16'h0005, 3, 4);
        push_frame(16'h0001, 2, 4);
        drive_frame(16'h0005, 3, 0, fa1, la1);
        drive_frame(16'h0001, 2, 0, fa2, la2);
        checks++;
        if (fa2 - la1 < 4 + 3) begin
            errors++;
            $display("FAIL b2b_gap: got %0d cycles, required at least 7", fa2 - la1);
        end
        wait_idle("b2b");
        checks++;
        if (sym_cnt != 13) begin errors++; $display("FAIL b2b_sym_count: got %0d, required 13", sym_cnt); end
        check_drained("b2b");
    endtask

    task automatic test_reset_tail();
        int a, fa, la;
        cfg = 2'b11;
        @(negedge clk);
        clear_stats();
        push_frame(16'h0003, 2, 6);
        drive_bit(1'b1, 1'b0, a);
        drive_bit(1'b1, 1'b1, a);
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_tail_pre: s_ready=%0b busy=%0b, required 0 1", s_ready, busy);
        end
        rst = 1'b1;
        exp_bits.delete();
        exp_last.delete();
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0 || bit_count !== '0) begin
            errors++;
            $display("FAIL rst_tail_state: s_ready=%0b busy=%0b bit_count=%0d, required 1 0 0",
                     s_ready, busy, bit_count);
        end
        clear_stats();
        repeat (12) @(negedge clk);
        checks++;
        if (sym_cnt != 0 || iss_cnt != 0) begin
            errors++;
            $display("FAIL rst_tail_flush: sym=%0d issued=%0d, required 0 0", sym_cnt, iss_cnt);
        end
        cfg = 2'b00;
        @(negedge clk);
        clear_stats();
        push_frame(16'h0001, 2, 2);
        drive_frame(16'h0001, 2, 0, fa, la);
        wait_idle("rst_recover");
        checks++;
        if (sym_cnt != 4) begin errors++; $display("FAIL rst_recover_count: got %0d, required 4", sym_cnt); end
        check_drained("rst");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_k3_frame();
        test_tail_len();
        test_cfg_freeze();
        test_gapped();
        test_overlen();
        test_back_to_back();
        test_reset_tail();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
